mem_stage: RTL and testbench

- MEM pipeline stage between EX and WB.
- Registers the EX→MEM bus under stall control and waits for a variable-latency data-SRAM read response.
- Aligns and sign/zero-extends load data, then drives mem_to_wb_bus (consumed by WB) and mem_to_rf_bus (forwarding to ID).
- Requests a pipeline stall while a load response is outstanding.

---
 rtl/mem_stage_pkg.sv | 46 ++++
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, stall encoding,
// load_op bit indices and the EX->MEM / MEM->WB bundles.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 147;
  localparam int MEM_TO_WB_WD = 136;
  localparam int STALL_W      = 6;
  localparam int MEM_STALL    = 3;
  localparam int WB_STALL     = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int LOP_LB  = 4;
  localparam int LOP_LBU = 3;
  localparam int LOP_LH  = 2;
  localparam int LOP_LHU = 1;
  localparam int LOP_LW  = 0;

  typedef struct packed {
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic [4:0]  load_op;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_wb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_st_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extract/extend: picks byte/half/word by addr, sign or
// zero extends per one-hot load_op. Ports: data, addr, load_op -> result.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  logic [4:0]  load_op,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = data[{addr, 3'b000} +: 8];
    h = addr[1] ? data[31:16] : data[15:0];
    result = data;
    unique case (1'b1)
      load_op[LOP_LB]:  result = {{24{b[7]}}, b};
      load_op[LOP_LBU]: result = {24'd0, b};
      load_op[LOP_LH]:  result = {{16{h[15]}}, h};
      load_op[LOP_LHU]: result = {16'd0, h};
      load_op[LOP_LW]:  result = data;
      default:          result = data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: registers EX bus, waits on SRAM read, aligns loads, feeds WB/ID.
// Ports: clk, rst(n), stall, ex_to_mem_bus, data_sram_* -> mem_to_wb_bus,
// mem_to_rf_bus, stallreq_for_mem; excp_adel when MEM_ALIGN_CHECK_EN defined.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus,
  output logic                    stallreq_for_mem
`ifdef MEM_ALIGN_CHECK_EN
  ,output logic                   excp_adel
`endif
);

  ex_mem_t     bus_r;
  mem_wb_t     wb;
  mem_st_e     st, st_nxt;
  logic [31:0] rdata_q, src, ld_res, wdata;
  logic        hold, bubble, ld_raw, is_load;
  logic        got, capture, we;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};

  // hold: MEM and WB both frozen; bubble: MEM frozen, WB drains
  assign hold   = (stall[MEM_STALL] == STOP) &&
                  (stall[WB_STALL] == STOP);
  assign bubble = (stall[MEM_STALL] == STOP) &&
                  (stall[WB_STALL] == NO_STOP);

  always_ff @(posedge clk) begin
    if (!rst)
      bus_r <= '0;
    else if (bubble)
      bus_r <= '0;
    else if (stall[MEM_STALL] == NO_STOP)
      bus_r <= ex_mem_t'(ex_to_mem_bus);
  end

  assign ld_raw = bus_r.data_ram_en &&
                  (bus_r.data_ram_wen == 4'd0) &&
                  (|bus_r.load_op);

`ifdef MEM_ALIGN_CHECK_EN
  logic misal;
  assign misal =
    ((bus_r.load_op[LOP_LH] | bus_r.load_op[LOP_LHU]) &
     bus_r.ex_result[0]) |
    (bus_r.load_op[LOP_LW] & (|bus_r.ex_result[1:0]));
  assign excp_adel = ld_raw & misal;
  assign is_load   = ld_raw & ~misal;
`else
  assign is_load   = ld_raw;
`endif

  assign got     = (st == DONE);
  assign capture = is_load & data_sram_rvalid & ~got;
  assign stallreq_for_mem = is_load & ~got & ~data_sram_rvalid;

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:
        if (is_load)
          st_nxt = data_sram_rvalid ? (hold ? DONE : IDLE)
                                    : WAIT;
      WAIT:
        if (!is_load)
          st_nxt = IDLE;
        else if (data_sram_rvalid)
          st_nxt = hold ? DONE : IDLE;
      DONE:
        if (!hold)
          st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= IDLE;
      rdata_q <= '0;
    end else begin
      st <= st_nxt;
      if (capture)
        rdata_q <= data_sram_rdata;
    end
  end

  // once captured, a repeat rvalid must not disturb the held word
  assign src = (data_sram_rvalid & ~got) ? data_sram_rdata
                                         : rdata_q;

  mem_stage_load_align u_align (
    .data    (src),
    .addr    (bus_r.ex_result[1:0]),
    .load_op (bus_r.load_op),
    .result  (ld_res)
  );

  assign wdata = bus_r.sel_rf_res ? ld_res : bus_r.ex_result;

`ifdef MEM_ALIGN_CHECK_EN
  assign we = bus_r.rf_we & ~stallreq_for_mem & ~excp_adel;
`else
  assign we = bus_r.rf_we & ~stallreq_for_mem;
`endif

  always_comb begin
    wb          = '0;
    wb.hilo_bus = bus_r.hilo_bus;
    wb.pc       = bus_r.pc;
    wb.rf_we    = we;
    wb.rf_waddr = bus_r.rf_waddr;
    wb.rf_wdata = wdata;
  end

  assign mem_to_wb_bus = wb;
  assign mem_to_rf_bus = {we, bus_r.rf_waddr, wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a queue of expected WB writes.
// Checks reset, ALU pass-through, load waits, held capture, bubble.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [5:0] RUN  = 6'b000000;
  localparam logic [5:0] HOLD = 6'b011111;
  localparam logic [5:0] BUBL = 6'b001111;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  ex_mem_t       ex_bus;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [135:0]  wb;
  logic [37:0]   rf;
  logic          sreq;
`ifdef MEM_ALIGN_CHECK_EN
  logic          excp_adel;
`endif

  int cmp_n = 0;
  int err_n = 0;
  logic [37:0] sbq[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_bus),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .mem_to_wb_bus    (wb),
    .mem_to_rf_bus    (rf),
    .stallreq_for_mem (sreq)
`ifdef MEM_ALIGN_CHECK_EN
    ,.excp_adel       (excp_adel)
`endif
  );

  function automatic ex_mem_t mk(
    input logic        en,
    input logic [3:0]  wen,
    input logic [4:0]  lop,
    input logic        sel,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] res
  );
    ex_mem_t e;
    e.hilo_bus     = {2'b10, 32'hA5A5_0000, res};
    e.pc           = 32'hBFC0_0000 | {20'd0, res[11:0]};
    e.data_ram_en  = en;
    e.data_ram_wen = wen;
    e.load_op      = lop;
    e.sel_rf_res   = sel;
    e.rf_we        = we;
    e.rf_waddr     = wa;
    e.ex_result    = res;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [135:0] obs,
                     input logic [135:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [37:0] e;
    if (sbq.size() == 0) begin
      cmp_n++;
      err_n++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_wb"}, {98'd0, wb[37:0]}, {98'd0, e});
      chk({tag, "_rf"}, {98'd0, rf}, {98'd0, e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b0;
    stall  = RUN;
    rvalid = 1'b0;
    rdata  = 32'h1111_2222;
    ex_bus = mk(1'b0, 4'h0, 5'b0, 1'b0, 1'b1, 5'd1, 32'hFFFF);

    tick();
    tick();
    #4;
    chk("rst_wb", wb, '0);
    chk("rst_rf", {98'd0, rf}, '0);
    chk("rst_sreq", {135'd0, sreq}, '0);

    // ALU pass-through
    rst    = 1'b1;
    ex_bus = mk(1'b0, 4'h0, 5'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
    sbq.push_back({1'b1, 5'd5, 32'h0000_1234});
    tick();
    #4;
    chk("alu_sreq", {135'd0, sreq}, '0);
    chk("alu_pc", {104'd0, wb[69:38]}, {104'd0, 32'hBFC0_0234});
    chk("alu_hilo", {70'd0, wb[135:70]},
        {70'd0, 2'b10, 32'hA5A5_0000, 32'h0000_1234});
    pop_cmp("alu");

    // lb addr 3, rvalid three cycles late
    ex_bus = mk(1'b1, 4'h0, 5'b10000, 1'b1, 1'b1, 5'd7, 32'h1000_0003);
    sbq.push_back({1'b1, 5'd7, 32'hFFFF_FF80});
    tick();
    stall  = HOLD;
    ex_bus = mk(1'b1, 4'h0, 5'b00010, 1'b1, 1'b1, 5'd9, 32'h2000_0002);
    for (int i = 0; i < 3; i++) begin
      #4;
      chk($sformatf("lb_wait%0d", i), {135'd0, sreq}, 136'd1);
      chk($sformatf("lb_we%0d", i), {135'd0, wb[37]}, '0);
      tick();
    end
    rvalid = 1'b1;
    rdata  = 32'h80FF_0000;
    stall  = RUN;
    #4;
    chk("lb_sreq", {135'd0, sreq}, '0);
    pop_cmp("lb");

    // lhu addr 2, same-cycle response
    sbq.push_back({1'b1, 5'd9, 32'h0000_BEEF});
    tick();
    rvalid = 1'b1;
    rdata  = 32'hBEEF_1234;
    ex_bus = mk(1'b1, 4'h0, 5'b00001, 1'b1, 1'b1, 5'd10, 32'h3000_0000);
    #4;
    chk("lhu_sreq", {135'd0, sreq}, '0);
    pop_cmp("lhu");

    // lw completing while MEM held
    sbq.push_back({1'b1, 5'd10, 32'hCAFE_F00D});
    tick();
    rvalid = 1'b0;
    stall  = HOLD;
    ex_bus = mk(1'b1, 4'hF, 5'b0, 1'b0, 1'b0, 5'd0, 32'h4444);
    #4;
    chk("lw_sreq", {135'd0, sreq}, 136'd1);
    tick();
    rvalid = 1'b1;
    rdata  = 32'hCAFE_F00D;
    #4;
    chk("lw_cap_sreq", {135'd0, sreq}, '0);
    chk("lw_cap_data", {104'd0, wb[31:0]}, {104'd0, 32'hCAFE_F00D});
    tick();
    rdata = 32'hDEAD_BEEF;
    #4;
    chk("lw_spur_sreq", {135'd0, sreq}, '0);
    chk("lw_spur_data", {104'd0, wb[31:0]}, {104'd0, 32'hCAFE_F00D});
    tick();
    rvalid = 1'b0;
    #4;
    chk("lw_held_data", {104'd0, wb[31:0]}, {104'd0, 32'hCAFE_F00D});
    tick();
    stall = RUN;
    #4;
    pop_cmp("lw_rel");

    // store passes through, no stall, no write
    sbq.push_back({1'b0, 5'd0, 32'h0000_4444});
    tick();
    ex_bus = mk(1'b0, 4'h0, 5'b0, 1'b0, 1'b1, 5'd3, 32'h55);
    stall  = BUBL;
    #4;
    chk("st_sreq", {135'd0, sreq}, '0);
    pop_cmp("store");

    // bubble
    tick();
    stall  = RUN;
    ex_bus = mk(1'b1, 4'h0, 5'b00001, 1'b1, 1'b1, 5'd11, 32'h5000_0000);
    #4;
    chk("bubble_wb", wb, '0);
    chk("bubble_sreq", {135'd0, sreq}, '0);

    // reset during WAIT
    tick();
    stall = HOLD;
    #4;
    chk("rw_sreq", {135'd0, sreq}, 136'd1);
    rst = 1'b0;
    tick();
    #4;
    chk("rw_sreq0", {135'd0, sreq}, '0);
    chk("rw_wb", wb, '0);
    rvalid = 1'b1;
    rdata  = 32'h0000_0999;
    ex_bus = mk(1'b0, 4'h0, 5'b0, 1'b0, 1'b1, 5'd4, 32'h77);
    sbq.push_back({1'b1, 5'd4, 32'h0000_0077});
    rst    = 1'b1;
    stall  = RUN;
    tick();
    rvalid = 1'b0;
    #4;
    chk("post_rst_sreq", {135'd0, sreq}, '0);
    pop_cmp("post_rst");

    // fresh load after reset must wait again
    ex_bus = mk(1'b1, 4'h0, 5'b00001, 1'b1, 1'b1, 5'd12, 32'h6000_0000);
    tick();
    stall = HOLD;
    #4;
    chk("fresh_sreq", {135'd0, sreq}, 136'd1);
    chk("fresh_we", {135'd0, wb[37]}, '0);

    chk("sbq_empty", 136'(sbq.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
